// File: rtl/add_resp_pkg.sv
// Shared constants and result-entry layout for the adder response collector.
// ADD_RESP_ZERO_EN adds a registered "result is zero" flag to each entry.
package add_resp_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_TAG_W = 4;
    localparam int DEF_LAT   = 4;
    localparam int DEF_DEPTH = 4;

    // Field order of an entry; the top declares the same layout at its own widths.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] sum;
        logic                 cout;
        logic [DEF_TAG_W-1:0] tag;
`ifdef ADD_RESP_ZERO_EN
        logic                 zero;
`endif
    } add_resp_entry_t;

endpackage

// File: rtl/add_resp_fifo.sv
// DEPTH-entry FIFO holding completed adder results; head is shown combinationally
// and forced to zero while empty so the response fields read 0 out of reset.
module add_resp_fifo #(
    parameter int DW    = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [DW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/add_resp_collector.sv
// Tracks operations issued to a fixed-latency adder and buffers their results in order.
// Optional ADD_RESP_ZERO_EN adds the rsp_zero output.
module add_resp_collector
    import add_resp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = DEF_LAT,
    parameter int DEPTH = DEF_DEPTH,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [TAG_W-1:0] req_tag,
    output logic             req_ready,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             err_ovf
`ifdef ADD_RESP_ZERO_EN
    ,
    output logic             rsp_zero
`endif
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int CRD_W = $clog2(LAT + DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic [TAG_W-1:0] tag;
`ifdef ADD_RESP_ZERO_EN
        logic             zero;
`endif
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic [LAT-1:0]            stage_valid_reg;
    logic [LAT-1:0]            stage_valid_next;
    logic [LAT-1:0][TAG_W-1:0] stage_tag_reg;
    logic [LAT-1:0][TAG_W-1:0] stage_tag_next;
    logic [CRD_W-1:0]          inflight;
    logic [CRD_W-1:0]          credit;
    logic [CNT_W-1:0]          fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_push;
    logic                      pop_fire;
    logic                      drop;
    logic                      err_ovf_reg;
    entry_t                    push_entry;
    entry_t                    head_entry;

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_valid_next[gi] = req_valid;
                assign stage_tag_next[gi]   = req_tag;
            end else begin : g_shift
                assign stage_valid_next[gi] = stage_valid_reg[gi-1];
                assign stage_tag_next[gi]   = stage_tag_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid_reg <= '0;
            stage_tag_reg   <= '0;
        end else begin
            stage_valid_reg <= stage_valid_next;
            stage_tag_reg   <= stage_tag_next;
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CRD_W'(stage_valid_reg[i]);
        end
    end

    // Credit uses registered state only, so a pop frees credit one cycle later.
    assign credit    = inflight + CRD_W'(fifo_count);
    assign req_ready = (credit < CRD_W'(DEPTH));

    assign fifo_push = stage_valid_reg[LAT-1];
    assign pop_fire  = rsp_valid && rsp_ready;
    assign drop      = fifo_push && fifo_full && !pop_fire;

    always_comb begin
        push_entry      = '0;
        push_entry.sum  = add_sum;
        push_entry.cout = add_cout;
        push_entry.tag  = stage_tag_reg[LAT-1];
`ifdef ADD_RESP_ZERO_EN
        push_entry.zero = (add_sum == '0) && !add_cout;
`endif
    end

    add_resp_fifo #(
        .DW    (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (pop_fire),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf_reg <= 1'b0;
        end else if ((req_valid && !req_ready) || drop) begin
            err_ovf_reg <= 1'b1;
        end
    end

    assign err_ovf   = err_ovf_reg;
    assign rsp_valid = !fifo_empty;
    assign rsp_sum   = head_entry.sum;
    assign rsp_cout  = head_entry.cout;
    assign rsp_tag   = head_entry.tag;
`ifdef ADD_RESP_ZERO_EN
    assign rsp_zero  = head_entry.zero;
`endif

endmodule

// File: tb/tb_add_resp_collector.sv
// Randomised bench for add_resp_collector with a queue-based reference model.
// Build with ADD_RESP_ZERO_EN to also exercise rsp_zero.
module tb_add_resp_collector;

    localparam int WIDTH = 32;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic [TAG_W-1:0] req_tag;
    logic             req_ready;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic [TAG_W-1:0] rsp_tag;
    logic             err_ovf;
`ifdef ADD_RESP_ZERO_EN
    logic             rsp_zero;
`endif

    add_resp_collector #(
        .WIDTH (WIDTH),
        .LAT   (LAT),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_ready (req_ready),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_tag   (rsp_tag),
        .err_ovf   (err_ovf)
`ifdef ADD_RESP_ZERO_EN
        ,
        .rsp_zero  (rsp_zero)
`endif
    );

    always #5 clk = ~clk;

    // An operation: result due from the adder in cycle 'due'.
    typedef struct {
        int               due;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } op_t;

    op_t inflight[$];
    op_t buffer[$];
    int  cyc = 0;
    bit  exp_err = 1'b0;
    int  checks = 0;
    int  errors = 0;

    function automatic bit exp_ready();
        return (inflight.size() + buffer.size()) < DEPTH;
    endfunction

    function automatic logic [WIDTH-1:0] rand_sum();
        if ($urandom_range(0, 5) == 0) return '0;
        return WIDTH'($urandom);
    endfunction

    // One clock cycle: entered and left at a falling edge.
    task automatic cycle(input bit rv, input logic [TAG_W-1:0] tg,
                         input logic [WIDTH-1:0] sm, input logic co, input bit rr);
        bit  er;
        bit  pop;
        op_t rec;
        er = exp_ready();
        checks++;
        if (rsp_valid !== (buffer.size() != 0)) begin
            errors++;
            $display("FAIL cyc%0d rsp_valid: got %b expected %b", cyc, rsp_valid, buffer.size() != 0);
        end
        checks++;
        if (req_ready !== er) begin
            errors++;
            $display("FAIL cyc%0d req_ready: got %b expected %b", cyc, req_ready, er);
        end
        checks++;
        if (err_ovf !== exp_err) begin
            errors++;
            $display("FAIL cyc%0d err_ovf: got %b expected %b", cyc, err_ovf, exp_err);
        end
        if (buffer.size() != 0) begin
            checks++;
            if (rsp_sum !== buffer[0].sum || rsp_cout !== buffer[0].cout || rsp_tag !== buffer[0].tag) begin
                errors++;
                $display("FAIL cyc%0d head: got sum=%h cout=%b tag=%h expected sum=%h cout=%b tag=%h",
                         cyc, rsp_sum, rsp_cout, rsp_tag, buffer[0].sum, buffer[0].cout, buffer[0].tag);
            end
`ifdef ADD_RESP_ZERO_EN
            checks++;
            if (rsp_zero !== ((buffer[0].sum == '0) && !buffer[0].cout)) begin
                errors++;
                $display("FAIL cyc%0d rsp_zero: got %b expected %b", cyc, rsp_zero,
                         (buffer[0].sum == '0) && !buffer[0].cout);
            end
`endif
        end
        req_valid = rv;
        req_tag   = tg;
        rsp_ready = rr;
        if (inflight.size() != 0 && inflight[0].due == cyc) begin
            add_sum  = inflight[0].sum;
            add_cout = inflight[0].cout;
        end else begin
            add_sum  = WIDTH'($urandom);
            add_cout = 1'($urandom);
        end
        @(posedge clk);
        pop = (buffer.size() != 0) && rr;
        if (rv && !er) exp_err = 1'b1;
        if (pop) void'(buffer.pop_front());
        if (inflight.size() != 0 && inflight[0].due == cyc) begin
            rec = inflight.pop_front();
            if (buffer.size() == DEPTH) exp_err = 1'b1;
            else buffer.push_back(rec);
        end
        if (rv) begin
            rec.due  = cyc + LAT;
            rec.tag  = tg;
            rec.sum  = sm;
            rec.cout = co;
            inflight.push_back(rec);
        end
        $display("cyc%0d req=%b tag=%h rdy=%b rsp_ready=%b occ=%0d inflight=%0d",
                 cyc, rv, tg, er, rr, buffer.size(), inflight.size());
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, rr);
    endtask

    // Called at a falling edge; leaves reset released at a falling edge.
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        inflight.delete();
        buffer.delete();
        exp_err = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%b ready=%b err=%b expected 0 1 0", rsp_valid, req_ready, err_ovf);
        end
        checks++;
        if (rsp_sum !== '0 || rsp_cout !== 1'b0 || rsp_tag !== '0) begin
            errors++;
            $display("FAIL reset_data: got sum=%h cout=%b tag=%h expected 0", rsp_sum, rsp_cout, rsp_tag);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        cycle(1'b1, 4'd3, 32'd4, 1'b0, 1'b1);
        for (int i = 0; i < LAT; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 32'd4 || rsp_tag !== 4'd3) begin
            errors++;
            $display("FAIL single_latency: got valid=%b sum=%h tag=%h expected 1 4 3", rsp_valid, rsp_sum, rsp_tag);
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_one_cycle: got valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int issued = 0;
        for (int i = 0; i < 8; i++) begin
            if (exp_ready()) begin
                cycle(1'b1, TAG_W'(issued), rand_sum(), 1'($urandom), 1'b0);
                issued++;
            end else begin
                cycle(1'b0, '0, '0, 1'b0, 1'b0);
            end
        end
        checks++;
        if (req_ready !== 1'b0 || issued != DEPTH) begin
            errors++;
            $display("FAIL b2b_ready: got ready=%b issued=%0d expected 0 %0d", req_ready, issued, DEPTH);
        end
        idle(LAT, 1'b0);
        checks++;
        if (rsp_tag !== 4'd0 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_buffer: got tag=%h err=%b expected 0 0", rsp_tag, err_ovf);
        end
        idle(DEPTH + 1, 1'b1);
    endtask

    task automatic test_stream();
        logic [TAG_W-1:0] t = '0;
        for (int i = 0; i < DEPTH + LAT + 2; i++) begin
            if (exp_ready()) begin
                cycle(1'b1, t, rand_sum(), 1'($urandom), 1'b0);
                t++;
            end else begin
                cycle(1'b0, '0, '0, 1'b0, 1'b0);
            end
        end
        for (int i = 0; i < 48; i++) begin
            if (exp_ready()) begin
                cycle(1'b1, t, rand_sum(), 1'($urandom), 1'b1);
                t++;
            end else begin
                cycle(1'b0, '0, '0, 1'b0, 1'b1);
            end
        end
        idle(LAT + DEPTH + 2, 1'b1);
    endtask

    task automatic test_overflow();
        logic [TAG_W-1:0] t = 4'd8;
        for (int i = 0; i < DEPTH + LAT + 2; i++) begin
            if (exp_ready()) begin
                cycle(1'b1, t, rand_sum(), 1'($urandom), 1'b0);
                t++;
            end else begin
                cycle(1'b0, '0, '0, 1'b0, 1'b0);
            end
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'hF, rand_sum(), 1'b1, 1'b0);
        idle(LAT + 1, 1'b0);
        checks++;
        if (err_ovf !== 1'b1 || rsp_tag !== 4'd8) begin
            errors++;
            $display("FAIL ovf_sticky: got err=%b tag=%h expected 1 8", err_ovf, rsp_tag);
        end
        idle(DEPTH + 3, 1'b1);
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 4'd1, rand_sum(), 1'b0, 1'b0);
        cycle(1'b1, 4'd2, rand_sum(), 1'b0, 1'b0);
        idle(LAT, 1'b0);
        cycle(1'b1, 4'd5, rand_sum(), 1'b0, 1'b0);
        cycle(1'b1, 4'd6, rand_sum(), 1'b0, 1'b0);
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_setup: got valid=%b ready=%b expected 1 0", rsp_valid, req_ready);
        end
        test_reset();
        idle(LAT + 3, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle(exp_ready() && ($urandom_range(0, 99) < 70), TAG_W'($urandom),
                  rand_sum(), 1'($urandom), ($urandom_range(0, 99) < 50));
        end
        idle(LAT + DEPTH + 2, 1'b1);
    endtask

`ifdef ADD_RESP_ZERO_EN
    task automatic test_zero();
        cycle(1'b1, 4'd1, '0, 1'b0, 1'b0);
        cycle(1'b1, 4'd2, '0, 1'b1, 1'b0);
        idle(LAT, 1'b0);
        checks++;
        if (rsp_zero !== 1'b1) begin
            errors++;
            $display("FAIL zero_set: got %b expected 1", rsp_zero);
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        checks++;
        if (rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL zero_cout: got %b expected 0", rsp_zero);
        end
        idle(2, 1'b1);
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        add_sum   = '0;
        add_cout  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_stream();
        test_overflow();
        test_reset();
        test_reset_mid();
        test_random();
`ifdef ADD_RESP_ZERO_EN
        test_zero();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
